// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller and the paddle controllers.
// Holds the match FSM state encoding, the default playfield / paddle geometry,
// and a helper that tests whether a ball row lies on a paddle.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RUNNING    = 3'd1,
        P1_POINT   = 3'd2,
        P2_POINT   = 3'd3,
        MATCH_OVER = 3'd4
    } state_t;

    localparam int C_GAME_WIDTH    = 40;
    localparam int C_GAME_HEIGHT   = 30;
    localparam int C_PADDLE_HEIGHT = 6;
    localparam int C_P1_PADDLE_X   = 0;
    localparam int C_P2_PADDLE_X   = 39;
    localparam int C_BALL_SPEED    = 1250000;
    localparam int C_SCORE_LIMIT   = 9;

    // A paddle covers top..top+height inclusive. The bottom row is formed at
    // 7 bits so a paddle near row 63 does not wrap back to the top.
    function automatic logic in_paddle(input logic [5:0] y,
                                       input logic [5:0] top,
                                       input int         height);
        logic [6:0] bottom;
        bottom = {1'b0, top} + 7'(height);
        return (y >= top) && ({1'b0, y} <= bottom);
    endfunction

endpackage

// File: rtl/pong_ball_tick.sv
// Ball step timer.
// Counts clocks while enabled and raises o_Tick for one clock each time the
// count equals c_BALL_SPEED, then wraps, giving one tick per c_BALL_SPEED+1
// clocks. Dropping i_En clears the count so every rally starts from zero.
// Ports:
//   i_Clk  - clock
//   i_Rst  - synchronous active-high reset
//   i_En   - count enable (high while the ball is in play)
//   o_Tick - one-clock step pulse
module pong_ball_tick
    import pong_pkg::*;
#(
    parameter int c_BALL_SPEED = C_BALL_SPEED
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_En,
    output logic o_Tick
);

    localparam int W = (c_BALL_SPEED > 0) ? $clog2(c_BALL_SPEED + 1) : 1;
    localparam logic [W-1:0] LAST = W'(c_BALL_SPEED);

    logic [W-1:0] count_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst || !i_En) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign o_Tick = i_En && (count_q == LAST);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: ball motion, wall and paddle bounces, scoring and
// match-over handling.
// Ports:
//   i_Clk, i_Rst                    - clock, synchronous active-high reset
//   i_Game_Start                    - level; serves from IDLE or restarts after a match
//   i_P1_Paddle_Y, i_P2_Paddle_Y    - top row of each paddle
//   i_Col_Count_Div, i_Row_Count_Div- game-unit coordinates of the current pixel
//   o_Ball_X, o_Ball_Y              - ball position
//   o_Draw_Ball                     - current game unit holds the ball (1 clock latency)
//   o_P1_Score, o_P2_Score          - points won
//   o_Game_Active                   - high while the ball is in play
//   o_Match_Over, o_Winner          - match finished; winner 0 = P1, 1 = P2
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int c_GAME_WIDTH    = C_GAME_WIDTH,
    parameter int c_GAME_HEIGHT   = C_GAME_HEIGHT,
    parameter int c_PADDLE_HEIGHT = C_PADDLE_HEIGHT,
    parameter int c_P1_PADDLE_X   = C_P1_PADDLE_X,
    parameter int c_P2_PADDLE_X   = C_P2_PADDLE_X,
    parameter int c_BALL_SPEED    = C_BALL_SPEED,
    parameter int c_SCORE_LIMIT   = C_SCORE_LIMIT
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Game_Start,
    input  logic [5:0] i_P1_Paddle_Y,
    input  logic [5:0] i_P2_Paddle_Y,
    input  logic [5:0] i_Col_Count_Div,
    input  logic [5:0] i_Row_Count_Div,
    output logic [5:0] o_Ball_X,
    output logic [5:0] o_Ball_Y,
    output logic       o_Draw_Ball,
    output logic [3:0] o_P1_Score,
    output logic [3:0] o_P2_Score,
    output logic       o_Game_Active,
    output logic       o_Match_Over,
    output logic       o_Winner
);

    localparam logic [5:0] X_CENTRE  = 6'(c_GAME_WIDTH / 2);
    localparam logic [5:0] Y_CENTRE  = 6'(c_GAME_HEIGHT / 2);
    localparam logic [5:0] Y_BOTTOM  = 6'(c_GAME_HEIGHT - 1);
    localparam logic [5:0] P1_X      = 6'(c_P1_PADDLE_X);
    localparam logic [5:0] P2_X      = 6'(c_P2_PADDLE_X);
    localparam logic [3:0] SCORE_MAX = 4'(c_SCORE_LIMIT);

    state_t     state_q;
    logic [5:0] ball_x_q, ball_y_q;
    logic       dir_x_q;            // 1 = moving right
    logic       dir_y_q;            // 1 = moving down
    logic [3:0] p1_score_q, p2_score_q;
    logic       draw_q, active_q, match_over_q, winner_q;

    logic       tick, tick_en;
    logic       dir_y_d;
    logic [5:0] ball_y_d;
    logic       at_p1, at_p2, p1_hit, p2_hit;
    logic [3:0] p1_score_d, p2_score_d;

    assign tick_en = (state_q == RUNNING);

    pong_ball_tick #(
        .c_BALL_SPEED(c_BALL_SPEED)
    ) u_tick (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_En  (tick_en),
        .o_Tick(tick)
    );

    // Wall bounce: the direction flips first, then the ball moves away from
    // the wall within the same step.
    always_comb begin
        dir_y_d = dir_y_q;
        if (!dir_y_q && ball_y_q == 6'd0) begin
            dir_y_d = 1'b1;
        end else if (dir_y_q && ball_y_q == Y_BOTTOM) begin
            dir_y_d = 1'b0;
        end
        ball_y_d = dir_y_d ? ball_y_q + 6'd1 : ball_y_q - 6'd1;
    end

    // Paddle checks use the row the ball occupies before this step's move.
    assign at_p1  = !dir_x_q && (ball_x_q == P1_X + 6'd1);
    assign at_p2  =  dir_x_q && (ball_x_q == P2_X - 6'd1);
    assign p1_hit = in_paddle(ball_y_q, i_P1_Paddle_Y, c_PADDLE_HEIGHT);
    assign p2_hit = in_paddle(ball_y_q, i_P2_Paddle_Y, c_PADDLE_HEIGHT);

    // Saturating increments keep the scores from passing the limit.
    assign p1_score_d = (p1_score_q < SCORE_MAX) ? p1_score_q + 4'd1 : p1_score_q;
    assign p2_score_d = (p2_score_q < SCORE_MAX) ? p2_score_q + 4'd1 : p2_score_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q      <= IDLE;
            ball_x_q     <= X_CENTRE;
            ball_y_q     <= Y_CENTRE;
            dir_x_q      <= 1'b1;
            dir_y_q      <= 1'b1;
            p1_score_q   <= '0;
            p2_score_q   <= '0;
            draw_q       <= 1'b0;
            active_q     <= 1'b0;
            match_over_q <= 1'b0;
            winner_q     <= 1'b0;
        end else begin
            draw_q <= (i_Col_Count_Div == ball_x_q) && (i_Row_Count_Div == ball_y_q)
                      && (state_q != MATCH_OVER);

            case (state_q)
                IDLE: begin
                    ball_x_q <= X_CENTRE;
                    ball_y_q <= Y_CENTRE;
                    if (i_Game_Start) begin
                        state_q  <= RUNNING;
                        active_q <= 1'b1;
                    end
                end

                RUNNING: begin
                    if (tick) begin
                        dir_y_q  <= dir_y_d;
                        ball_y_q <= ball_y_d;
                        if (at_p1) begin
                            if (p1_hit) begin
                                dir_x_q  <= 1'b1;
                                ball_x_q <= P1_X + 6'd2;
                            end else begin
                                ball_x_q <= P1_X;
                                state_q  <= P2_POINT;
                                active_q <= 1'b0;
                            end
                        end else if (at_p2) begin
                            if (p2_hit) begin
                                dir_x_q  <= 1'b0;
                                ball_x_q <= P2_X - 6'd2;
                            end else begin
                                ball_x_q <= P2_X;
                                state_q  <= P1_POINT;
                                active_q <= 1'b0;
                            end
                        end else begin
                            ball_x_q <= dir_x_q ? ball_x_q + 6'd1 : ball_x_q - 6'd1;
                        end
                    end
                end

                // Next serve heads toward the player who conceded.
                P1_POINT: begin
                    p1_score_q <= p1_score_d;
                    dir_x_q    <= 1'b1;
                    ball_x_q   <= X_CENTRE;
                    ball_y_q   <= Y_CENTRE;
                    if (p1_score_d == SCORE_MAX) begin
                        state_q      <= MATCH_OVER;
                        match_over_q <= 1'b1;
                        winner_q     <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end

                P2_POINT: begin
                    p2_score_q <= p2_score_d;
                    dir_x_q    <= 1'b0;
                    ball_x_q   <= X_CENTRE;
                    ball_y_q   <= Y_CENTRE;
                    if (p2_score_d == SCORE_MAX) begin
                        state_q      <= MATCH_OVER;
                        match_over_q <= 1'b1;
                        winner_q     <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end

                MATCH_OVER: begin
                    if (i_Game_Start) begin
                        p1_score_q   <= '0;
                        p2_score_q   <= '0;
                        ball_x_q     <= X_CENTRE;
                        ball_y_q     <= Y_CENTRE;
                        state_q      <= RUNNING;
                        active_q     <= 1'b1;
                        match_over_q <= 1'b0;
                    end
                end

                default: begin
                    state_q  <= IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_Ball_X      = ball_x_q;
    assign o_Ball_Y      = ball_y_q;
    assign o_Draw_Ball   = draw_q;
    assign o_P1_Score    = p1_score_q;
    assign o_P2_Score    = p2_score_q;
    assign o_Game_Active = active_q;
    assign o_Match_Over  = match_over_q;
    assign o_Winner      = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl with c_BALL_SPEED=3 (one step per 4 clocks) and
// c_SCORE_LIMIT=2. Expected output snapshots, keyed by clock-edge number, are
// queued by the stimulus process; a monitor on the falling edge pops and
// compares them. Ball trajectories below were worked out by hand.
module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] p1y = 6'd8, p2y = 6'd20;
    logic [5:0] col = 6'd63, row = 6'd63;

    logic [5:0] ball_x, ball_y;
    logic       draw, active, match_over, winner;
    logic [3:0] p1_score, p2_score;

    pong_match_ctrl #(
        .c_BALL_SPEED (3),
        .c_SCORE_LIMIT(2)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Game_Start   (start),
        .i_P1_Paddle_Y  (p1y),
        .i_P2_Paddle_Y  (p2y),
        .i_Col_Count_Div(col),
        .i_Row_Count_Div(row),
        .o_Ball_X       (ball_x),
        .o_Ball_Y       (ball_y),
        .o_Draw_Ball    (draw),
        .o_P1_Score     (p1_score),
        .o_P2_Score     (p2_score),
        .o_Game_Active  (active),
        .o_Match_Over   (match_over),
        .o_Winner       (winner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Snapshot layout: x[23:18] y[17:12] p1[11:8] p2[7:4] act[3] mo[2] win[1] draw[0]
    typedef struct {
        int          c;
        string       nm;
        logic [23:0] v;
        logic [23:0] m;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   end_req = 1'b0;

    task automatic push(input int c, input string nm, input int x, input int y,
                        input int s1, input int s2, input bit act, input bit mo,
                        input bit win, input bit dr, input bit cxy, input bit cwin);
        exp_t e;
        e.c  = c;
        e.nm = nm;
        e.v  = {6'(x), 6'(y), 4'(s1), 4'(s2), act, mo, win, dr};
        e.m  = {cxy ? 12'hfff : 12'h000, 8'hff, 1'b1, 1'b1, cwin, 1'b1};
        sbq.push_back(e);
    endtask

    // Ball-in-play snapshot shorthand: no match over, draw low.
    task automatic run(input int c, input string nm, input int x, input int y,
                       input int s1, input int s2, input bit act);
        push(c, nm, x, y, s1, s2, act, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic tick_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t        e;
        logic [23:0] got;
        got = {ball_x, ball_y, p1_score, p2_score, active, match_over, winner, draw};
        while (sbq.size() > 0 && (sbq[0].c <= cyc || end_req)) begin
            e = sbq.pop_front();
            checks++;
            if (e.c != cyc) begin
                errors++;
                $display("FAIL %s: snapshot for edge %0d not taken (now edge %0d)", e.nm, e.c, cyc);
            end else if ((got & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("FAIL %s @%0d: got x=%0d y=%0d p1=%0d p2=%0d act=%b mo=%b win=%b draw=%b; want x=%0d y=%0d p1=%0d p2=%0d act=%b mo=%b win=%b draw=%b (mask %h)",
                         e.nm, cyc, ball_x, ball_y, p1_score, p2_score, active, match_over, winner, draw,
                         e.v[23:18], e.v[17:12], e.v[11:8], e.v[7:4], e.v[3], e.v[2], e.v[1], e.v[0], e.m);
            end
        end
    end

    initial begin
        int s, t, u, v;
        s = 5;          // edge entering RUNNING for rally A
        t = s + 374;    // rally B entry
        u = t + 226;    // rally C entry
        v = u + 86;     // restart after the match

        push(3, "reset_state", 20, 15, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick_to(3);
        rst = 1'b0;

        // Rally A: serve right/down, P1 paddle rows 8..14, P2 paddle rows 20..26.
        tick_to(4);
        start = 1'b1;
        run(s,       "start_active",    20, 15, 0, 0, 1'b1);
        run(s + 3,   "before_step1",    20, 15, 0, 0, 1'b1);
        run(s + 4,   "step1",           21, 16, 0, 0, 1'b1);
        run(s + 60,  "floor_bounce",    35, 28, 0, 0, 1'b1);
        run(s + 76,  "p2_hit",          37, 24, 0, 0, 1'b1);
        run(s + 80,  "after_p2_hit",    36, 23, 0, 0, 1'b1);
        run(s + 172, "reach_ceiling",   13,  0, 0, 0, 1'b1);
        run(s + 176, "ceiling_bounce",  12,  1, 0, 0, 1'b1);
        run(s + 224, "p1_hit",           2, 13, 0, 0, 1'b1);
        run(s + 228, "after_p1_hit",     3, 14, 0, 0, 1'b1);
        run(s + 292, "floor_bounce2",   19, 28, 0, 0, 1'b1);
        run(s + 372, "p2_miss",         39,  8, 0, 0, 1'b0);
        run(s + 373, "p1_scores",       20, 15, 1, 0, 1'b0);
        run(s + 374, "serve_b",         20, 15, 1, 0, 1'b1);
        tick_to(s + 2);
        start = 1'b0;           // was held through two RUNNING edges
        tick_to(s + 371);
        start = 1'b1;           // held through the point state as well

        // Rally B: serve right/up, both paddles at rows 0..6.
        tick_to(t);
        start = 1'b0;
        p1y   = 6'd0;
        p2y   = 6'd0;
        run(t + 64,  "b_ceiling_bounce", 36,  1, 1, 0, 1'b1);
        run(t + 76,  "b_p2_hit",         37,  4, 1, 0, 1'b1);
        run(t + 220, "b_near_p1",         1, 18, 1, 0, 1'b1);
        run(t + 224, "b_p1_miss",         0, 17, 1, 0, 1'b0);
        run(t + 225, "b_p2_scores",      20, 15, 1, 1, 1'b0);
        run(t + 226, "serve_c",          20, 15, 1, 1, 1'b1);
        tick_to(t + 223);
        start = 1'b1;

        // Rally C: serve left/up, P1 paddle rows 10..16 -> miss at row 4.
        tick_to(u);
        start = 1'b0;
        p1y   = 6'd10;
        run(u + 60, "c_reach_ceiling", 5, 0, 1, 1, 1'b1);
        run(u + 64, "c_ceiling_bounce", 4, 1, 1, 1, 1'b1);
        run(u + 76, "c_near_p1",        1, 4, 1, 1, 1'b1);
        run(u + 80, "c_p1_miss",        0, 5, 1, 1, 1'b0);
        push(u + 81, "match_over",     0, 0, 1, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        push(u + 82, "mo_draw_ball",   0, 0, 1, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        push(u + 83, "mo_draw_centre", 0, 0, 1, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        push(u + 85, "mo_hold",        0, 0, 1, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick_to(u + 81);
        col = 6'd0;
        row = 6'd5;
        tick_to(u + 82);
        col = 6'd20;
        row = 6'd15;
        tick_to(u + 83);
        col = 6'd63;
        row = 6'd63;
        tick_to(u + 85);
        start = 1'b1;
        run(v, "restart", 20, 15, 0, 0, 1'b1);

        // Reset lands on the edge that would carry the first step.
        tick_to(v);
        start = 1'b0;
        run(v + 3, "before_reset", 20, 15, 0, 0, 1'b1);
        push(v + 4, "reset_on_tick", 20, 15, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        push(v + 5, "reset_no_move", 20, 15, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick_to(v + 3);
        rst = 1'b1;
        tick_to(v + 4);
        rst = 1'b0;

        // Draw flag in IDLE, one clock after the coordinates are applied.
        push(v + 6, "draw_hit",  20, 15, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        push(v + 7, "draw_miss", 20, 15, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick_to(v + 5);
        col = 6'd20;
        row = 6'd15;
        tick_to(v + 6);
        col = 6'd21;

        tick_to(v + 9);
        end_req = 1'b1;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 SHALL have parameter c_GAME_WIDTH, default 40: playfield columns in board game units.
REQ-002 SHALL have parameter c_GAME_HEIGHT, default 30: playfield rows in board game units.
REQ-003 SHALL have parameter c_PADDLE_HEIGHT, default 6: a paddle spans rows Paddle_Y..Paddle_Y+c_PADDLE_HEIGHT inclusive.
REQ-004 SHALL have parameters c_P1_PADDLE_X, default 0, and c_P2_PADDLE_X, default 39: paddle columns.
REQ-005 SHALL have parameter c_BALL_SPEED, default 1250000: one ball step per c_BALL_SPEED+1 clocks.
REQ-006 SHALL have parameter c_SCORE_LIMIT, default 9: points needed to win the match.
REQ-007 SHALL have port i_Clk, input, 1: the single clock; all logic on its rising edge.
REQ-008 SHALL have port i_Rst, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port i_Game_Start, input, 1: level; serves or restarts play.
REQ-010 SHALL have ports i_P1_Paddle_Y and i_P2_Paddle_Y, input, 6 each: top row of each paddle.
REQ-011 SHALL have ports i_Col_Count_Div and i_Row_Count_Div, input, 6 each: current pixel's game-unit coordinates.
REQ-012 SHALL have ports o_Ball_X and o_Ball_Y, output, 6 each: ball position.
REQ-013 SHALL have port o_Draw_Ball, output, 1: current game unit holds the ball.
REQ-014 SHALL have ports o_P1_Score and o_P2_Score, output, 4 each: points won.
REQ-015 SHALL have port o_Game_Active, output, 1: high only in RUNNING.
REQ-016 SHALL have port o_Match_Over, output, 1, and port o_Winner, output, 1: o_Winner is 0 for P1, 1 for P2, and is valid while o_Match_Over is high.

Function
REQ-017 SHALL implement FSM states IDLE, RUNNING, P1_POINT, P2_POINT, MATCH_OVER.
REQ-018 IDLE SHALL hold the ball at (c_GAME_WIDTH/2, c_GAME_HEIGHT/2) and go to RUNNING on the clock edge where i_Game_Start=1.
REQ-019 The step counter SHALL clear on entering RUNNING, count only in RUNNING, and raise a tick when it equals c_BALL_SPEED, then wrap to 0; the first step occurs c_BALL_SPEED+1 clocks after entry.
REQ-020 On a tick, Y SHALL move by ±1; when moving up at Y=0 or moving down at Y=c_GAME_HEIGHT-1, the Y direction SHALL flip before the move in the same tick.
REQ-021 On a tick with the ball moving left at X=c_P1_PADDLE_X+1: if Y is within P1's paddle rows, the X direction SHALL flip and X becomes c_P1_PADDLE_X+2; otherwise X becomes c_P1_PADDLE_X and the FSM goes to P2_POINT.
REQ-022 REQ-021 SHALL apply symmetrically for P2, moving right at X=c_P2_PADDLE_X-1, with a miss going to P1_POINT.
REQ-023 A wall bounce and a paddle hit on the same tick SHALL both apply independently, flipping both directions.
REQ-024 P1_POINT and P2_POINT SHALL last one clock each: increment the scorer's count; go to MATCH_OVER if the new count equals c_SCORE_LIMIT, else to IDLE.
REQ-025 On returning to IDLE, the serve X direction SHALL point toward the player who conceded; Y direction SHALL be unchanged.
REQ-026 MATCH_OVER SHALL assert o_Match_Over and hold the scores and o_Winner; i_Game_Start=1 SHALL clear both scores and go to RUNNING with the ball centred.
REQ-027 i_Game_Start SHALL be ignored in RUNNING, P1_POINT and P2_POINT.
REQ-028 o_Draw_Ball SHALL be registered with one-clock latency: 1 iff col=o_Ball_X and row=o_Ball_Y, and the state is not MATCH_OVER.
REQ-029 Scores SHALL never exceed c_SCORE_LIMIT; all coordinate comparisons SHALL be unsigned 6-bit, with the paddle bottom computed at 7 bits.

Reset
REQ-030 i_Rst SHALL force IDLE, clear the counter, centre the ball with direction right/down, zero both scores, and drive o_Draw_Ball, o_Game_Active, o_Match_Over and o_Winner to 0 on the next edge.
REQ-031 Reset SHALL take priority over every event, including a tick or point in the same cycle.

Structure
REQ-032 Package pong_pkg SHALL hold the FSM state encoding and the default playfield and paddle constants shared with the paddle controllers.
REQ-033 The step counter SHALL be sub-module pong_ball_tick, with inputs clock, reset and enable, parameter c_BALL_SPEED, and a one-clock tick output.

Verification (c_BALL_SPEED=3, c_SCORE_LIMIT=2, other parameters default)
REQ-034 Reset, then pulse Start -> o_Game_Active=1 next edge; first move 4 clocks later, ball (20,15) -> (21,16).
REQ-035 Ball at (10,29) moving down-right, tick -> (11,28), moving up.
REQ-036 Ball at (1,10) moving left, i_P1_Paddle_Y=8 -> (2,11 or 9) moving right, no score.
REQ-037 Ball at (1,20) moving left, i_P1_Paddle_Y=0 -> P2_POINT, o_P2_Score=1, IDLE, ball (20,15), serve left.
REQ-038 Second P2 miss -> o_Match_Over=1, o_Winner=1, score held; Start -> scores 0, RUNNING.
REQ-039 Assert i_Rst mid-RUNNING on a tick cycle -> IDLE, ball (20,15), scores 0, no move.
